// File: rtl/filter_mc_if.sv
// filter_mc_if: enable, raw inputs and filtered outputs of the debounce filter
interface filter_mc_if #(parameter int CH = 4);
  logic en;
  logic [CH-1:0] din;
  logic [CH-1:0] y;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic sample_tick;
  modport master(output en, din, input y, rise, fall, sample_tick);
  modport slave(input en, din, output y, rise, fall, sample_tick);
endinterface

// File: rtl/filter_mc.sv
// filter_mc: multi-channel debounce filter with prescaled sampling, hysteresis and edge pulses
module filter_mc #(
  parameter int CH = 4,
  parameter int DEPTH = 4,
  parameter int PRESCALE = 1
) (
  input logic clk,
  input logic rst_n,
  filter_mc_if.slave bus
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt;
  logic [CH-1:0][DEPTH-2:0] hist;
  logic [CH-1:0] rise_n, fall_n;
  logic tick;
  assign tick = bus.en && cnt == CW'(PRESCALE - 1);
  // the window is the stored history plus the sample being taken on this edge
  always_comb begin
    rise_n = '0;
    fall_n = '0;
    for (int i = 0; i < CH; i++) begin
      rise_n[i] = tick && (&{hist[i], bus.din[i]}) && !bus.y[i];
      fall_n[i] = tick && !(|{hist[i], bus.din[i]}) && bus.y[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      hist <= '0;
      bus.y <= '0;
      bus.rise <= '0;
      bus.fall <= '0;
      bus.sample_tick <= 1'b0;
    end else begin
      bus.rise <= rise_n;
      bus.fall <= fall_n;
      bus.sample_tick <= tick;
      bus.y <= (bus.y | rise_n) & ~fall_n;
      if (bus.en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        for (int i = 0; i < CH; i++) hist[i] <= (DEPTH - 1)'({hist[i], bus.din[i]});
    end
  end
endmodule

// File: tb/tb_filter_mc.sv
// tb_filter_mc: scoreboarded checks of filter_mc at PRESCALE=1 plus directed PRESCALE=3 checks
module tb_filter_mc;
  localparam int CH = 4;
  localparam int D = 4;
  typedef struct {
    logic [CH-1:0] y;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [CH-1:0] m_y, m_lv;
  int m_run[CH];
  always #5 clk = ~clk;
  filter_mc_if #(.CH(CH)) b1();
  filter_mc_if #(.CH(CH)) b3();
  filter_mc #(.CH(CH), .DEPTH(D), .PRESCALE(1)) dut(.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  filter_mc #(.CH(CH), .DEPTH(D), .PRESCALE(3)) dut3(.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  // run-length model: reset history counts as DEPTH-1 low samples
  task automatic model_reset();
    m_y = '0;
    m_lv = '0;
    for (int i = 0; i < CH; i++) m_run[i] = D - 1;
  endtask

  task automatic step(input logic e, input logic [CH-1:0] d);
    exp_t x, o;
    @(negedge clk);
    b1.en = e;
    b1.din = d;
    x.r = '0;
    x.f = '0;
    x.t = e;
    if (e)
      for (int i = 0; i < CH; i++) begin
        if (d[i] == m_lv[i]) m_run[i]++;
        else begin
          m_lv[i] = d[i];
          m_run[i] = 1;
        end
        if (m_run[i] >= D && m_y[i] != m_lv[i]) begin
          m_y[i] = m_lv[i];
          if (m_lv[i]) x.r[i] = 1'b1;
          else x.f[i] = 1'b1;
        end
      end
    x.y = m_y;
    q.push_back(x);
    @(posedge clk);
    #1;
    o = q.pop_front();
    checks++;
    if ({b1.y, b1.rise, b1.fall, b1.sample_tick} !== {o.y, o.r, o.f, o.t}) begin
      errors++;
      $display("FAIL scoreboard din=%b en=%b got y=%b rise=%b fall=%b tick=%b exp y=%b rise=%b fall=%b tick=%b",
               d, e, b1.y, b1.rise, b1.fall, b1.sample_tick, o.y, o.r, o.f, o.t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.en = 1'b1;
    b1.din = '1;
    b3.en = 1'b1;
    b3.din = '1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({b1.y, b1.rise, b1.fall, b1.sample_tick, b3.y, b3.rise, b3.fall, b3.sample_tick} !== '0) begin
        errors++;
        $display("FAIL reset_hold got p1=%b/%b/%b/%b p3=%b/%b/%b/%b exp all zero",
                 b1.y, b1.rise, b1.fall, b1.sample_tick, b3.y, b3.rise, b3.fall, b3.sample_tick);
      end
    end
    @(negedge clk);
    b1.en = 1'b0;
    b1.din = '0;
    b3.en = 1'b0;
    b3.din = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_prescale();
    logic [2*CH:0] want;
    @(negedge clk);
    b3.en = 1'b1;
    b3.din = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      want = {e % 3 == 0, (e >= 12) ? 4'b0100 : 4'b0000, (e == 12) ? 4'b0100 : 4'b0000};
      checks++;
      if ({b3.sample_tick, b3.y, b3.rise} !== want) begin
        errors++;
        $display("FAIL prescale edge=%0d got tick/y/rise=%b exp=%b", e, {b3.sample_tick, b3.y, b3.rise}, want);
      end
    end
    // one enabled edge, a frozen stretch, then the partial period must resume
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      b3.en = (e == 0 || e >= 6);
      b3.din = 4'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({b3.sample_tick, b3.rise, b3.fall} !== {e == 7, 8'h00}) begin
        errors++;
        $display("FAIL prescale_hold step=%0d got tick=%b rise=%b fall=%b exp tick=%b", e, b3.sample_tick, b3.rise, b3.fall, e == 7);
      end
    end
    @(negedge clk);
    b3.en = 1'b0;
    b3.din = '0;
  endtask

  task automatic test_step();
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001);
    checks++;
    if (b1.y !== 4'b0000) begin
      errors++;
      $display("FAIL step_early got y=%b exp=%b", b1.y, 4'b0000);
    end
    step(1'b1, 4'b0001);
    checks++;
    if ({b1.y, b1.rise} !== {4'b0001, 4'b0001}) begin
      errors++;
      $display("FAIL step_rise got y=%b rise=%b exp y=0001 rise=0001", b1.y, b1.rise);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0000);
    checks++;
    if ({b1.y, b1.fall} !== {4'b0000, 4'b0001}) begin
      errors++;
      $display("FAIL step_fall got y=%b fall=%b exp y=0000 fall=0001", b1.y, b1.fall);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0010);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0000);
    checks++;
    if (b1.y !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_high got y=%b exp=%b", b1.y, 4'b0000);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0010);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0010);
    checks++;
    if (b1.y !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_low got y=%b exp=%b", b1.y, 4'b0010);
    end
  endtask

  task automatic test_enable();
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1010);
    for (int k = 0; k < 10; k++) step(1'b0, 4'($urandom));
    step(1'b1, 4'b1010);
    checks++;
    if (b1.y !== 4'b0010) begin
      errors++;
      $display("FAIL enable_resume1 got y=%b exp=%b", b1.y, 4'b0010);
    end
    step(1'b1, 4'b1010);
    checks++;
    if ({b1.y, b1.rise} !== {4'b1010, 4'b1000}) begin
      errors++;
      $display("FAIL enable_resume2 got y=%b rise=%b exp y=1010 rise=1000", b1.y, b1.rise);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0101);
    checks++;
    if (b1.y !== 4'b1010) begin
      errors++;
      $display("FAIL simul_early got y=%b exp=%b", b1.y, 4'b1010);
    end
    step(1'b1, 4'b0101);
    checks++;
    if ({b1.y, b1.rise, b1.fall} !== {4'b0101, 4'b0101, 4'b1010}) begin
      errors++;
      $display("FAIL simul got y=%b rise=%b fall=%b exp y=0101 rise=0101 fall=1010", b1.y, b1.rise, b1.fall);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1111);
    checks++;
    if (b1.y !== 4'b1111) begin
      errors++;
      $display("FAIL async_pre got y=%b exp=%b", b1.y, 4'b1111);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b1.y, b1.rise, b1.fall} !== '0) begin
      errors++;
      $display("FAIL async_now got y=%b rise=%b fall=%b exp all zero", b1.y, b1.rise, b1.fall);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({b1.y, b1.fall, b1.sample_tick} !== '0) begin
      errors++;
      $display("FAIL async_edge got y=%b fall=%b tick=%b exp all zero", b1.y, b1.fall, b1.sample_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_step();
    test_glitch();
    test_enable();
    test_simultaneous();
    test_async_reset();
    step(1'b1, 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
